button_conditioner: RTL and testbench

- Upstream input stage for the slot-machine main FSM.
- Takes raw push-button inputs (coin insert, game start, three stop buttons, spare): synchronises each, debounces each independently, and emits a stable level plus a single-cycle press pulse per channel.
- The main FSM consumes only the BTN_PULSE outputs. One coin press becomes exactly one C_IN pulse, so a long press can never add several coins.

---
 rtl/button_conditioner.sv | 127 ++++++++++++
 tb/tb_button_conditioner.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// button_conditioner: per-channel polarity fix, 2-FF synchroniser, counter debouncer and press-pulse strobe.
// Optional macro BTN_AUTO_REPEAT_EN adds a held-button repeat pulse every REPEAT_CYCLES cycles.
module button_conditioner #(
    parameter int N_BTN      = 6,
    parameter int DB_CYCLES  = 250000,
    parameter int CNT_W      = 18,
    parameter bit ACTIVE_LOW = 1'b0
`ifdef BTN_AUTO_REPEAT_EN
    ,
    parameter int REPEAT_CYCLES = 12500000
`endif
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [N_BTN-1:0] BTN_RAW,
    input  logic [N_BTN-1:0] PULSE_MASK,
    output logic [N_BTN-1:0] BTN_LEVEL,
    output logic [N_BTN-1:0] BTN_PULSE,
    output logic             ANY_PRESS,
    output logic             BUSY
);
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);

    logic [N_BTN-1:0] pressed;
    logic [N_BTN-1:0] sync1_q, sync2_q;
    logic [N_BTN-1:0] level_q, level_d;
    logic [N_BTN-1:0] pulse_q, pulse_d;
    logic [N_BTN-1:0] rptFire;
    logic [CNT_W-1:0] cnt_q [N_BTN];
    logic [CNT_W-1:0] cnt_d [N_BTN];

    // Inversion happens before the synchroniser so everything downstream is "1 = pressed".
    assign pressed = BTN_RAW ^ {N_BTN{ACTIVE_LOW}};

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= pressed;
            sync2_q <= sync1_q;
        end
    end

    // Any agreement with the stable level restarts the count, so glitches never accumulate.
    always_comb begin
        level_d = level_q;
        for (int i = 0; i < N_BTN; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != level_q[i]) begin
                if (cnt_q[i] == DB_LAST) begin
                    level_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

`ifdef BTN_AUTO_REPEAT_EN
    localparam int RPT_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);

    logic [RPT_W-1:0] rpt_q [N_BTN];
    logic [RPT_W-1:0] rpt_d [N_BTN];

    // Repeat timer runs only while the level is, and stays, high; a falling edge never fires.
    always_comb begin
        rptFire = '0;
        for (int i = 0; i < N_BTN; i++) begin
            rpt_d[i] = '0;
            if (level_q[i] && level_d[i]) begin
                if (rpt_q[i] == RPT_LAST) begin
                    rptFire[i] = 1'b1;
                end else begin
                    rpt_d[i] = rpt_q[i] + RPT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < N_BTN; i++) begin
                rpt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                rpt_q[i] <= rpt_d[i];
            end
        end
    end
`else
    assign rptFire = '0;
`endif

    // Masked presses are dropped outright rather than held until the mask clears.
    assign pulse_d = ((level_d & ~level_q) | rptFire) & ~PULSE_MASK;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            level_q <= '0;
            pulse_q <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            level_q <= level_d;
            pulse_q <= pulse_d;
            for (int i = 0; i < N_BTN; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    always_comb begin
        BUSY = 1'b0;
        for (int i = 0; i < N_BTN; i++) begin
            BUSY = BUSY | (cnt_q[i] != '0);
        end
    end

    assign BTN_LEVEL = level_q;
    assign BTN_PULSE = pulse_q;
    assign ANY_PRESS = |pulse_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed self-checking bench for button_conditioner (DB_CYCLES=4, REPEAT_CYCLES=8).
// A second instance with ACTIVE_LOW=1 covers inverted buttons.
`timescale 1ns/1ps
module tb_button_conditioner;
    localparam int N = 6;

    logic         CLK = 1'b0;
    logic         RST;
    logic [N-1:0] rawA, rawB, mask, maskB;
    logic [N-1:0] levelA, pulseA, levelB, pulseB;
    logic         anyA, busyA, anyB, busyB;
    int           testCount = 0;
    int           failCount = 0;

    always #5 CLK = ~CLK;

    button_conditioner #(
        .N_BTN(N), .DB_CYCLES(4), .CNT_W(3), .ACTIVE_LOW(1'b0)
`ifdef BTN_AUTO_REPEAT_EN
        , .REPEAT_CYCLES(8)
`endif
    ) dut (
        .CLK(CLK), .RST(RST), .BTN_RAW(rawA), .PULSE_MASK(mask),
        .BTN_LEVEL(levelA), .BTN_PULSE(pulseA), .ANY_PRESS(anyA), .BUSY(busyA)
    );

    button_conditioner #(
        .N_BTN(N), .DB_CYCLES(4), .CNT_W(3), .ACTIVE_LOW(1'b1)
`ifdef BTN_AUTO_REPEAT_EN
        , .REPEAT_CYCLES(8)
`endif
    ) dutAl (
        .CLK(CLK), .RST(RST), .BTN_RAW(rawB), .PULSE_MASK(maskB),
        .BTN_LEVEL(levelB), .BTN_PULSE(pulseB), .ANY_PRESS(anyB), .BUSY(busyB)
    );

    // Reset holds every output at 0 even with every button pressed.
    task automatic test_reset();
        RST  = 1'b1;
        rawA = '1;
        rawB = '0;
        repeat (4) @(negedge CLK);
        testCount++;
        if ({levelA, pulseA, anyA, busyA} !== '0) begin
            failCount++;
            $display("[TB] FAIL reset_outputs_a: got %b want 0", {levelA, pulseA, anyA, busyA});
        end
        testCount++;
        if ({levelB, pulseB, anyB, busyB} !== '0) begin
            failCount++;
            $display("[TB] FAIL reset_outputs_b: got %b want 0", {levelB, pulseB, anyB, busyB});
        end
        rawA = '0;
        rawB = '1;
        @(negedge CLK);
        RST = 1'b0;
        repeat (8) @(negedge CLK);
        testCount++;
        if ({levelA, busyA, levelB, busyB} !== '0) begin
            failCount++;
            $display("[TB] FAIL reset_idle_after: got %b want 0", {levelA, busyA, levelB, busyB});
        end
    endtask

    task automatic test_clean_press();
        int  pulses, anys, relPulses;
        bit  risen;
        int  expHold, expRel;
`ifdef BTN_AUTO_REPEAT_EN
        expHold = 2;
        expRel  = 1;
`else
        expHold = 1;
        expRel  = 0;
`endif
        pulses = 0; anys = 0; relPulses = 0; risen = 0;
        rawA[0] = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge CLK);
            if (k == 3) begin
                testCount++;
                if (levelA[0] !== 1'b0) begin
                    failCount++;
                    $display("[TB] FAIL clean_level_early: got %b want 0", levelA[0]);
                end
            end
            if (k == 6) begin
                testCount++;
                if (levelA[0] !== 1'b1) begin
                    failCount++;
                    $display("[TB] FAIL clean_level_high: got %b want 1", levelA[0]);
                end
            end
            if (!risen && levelA[0] === 1'b1) begin
                risen = 1'b1;
                testCount++;
                if (pulseA[0] !== 1'b1 || anyA !== 1'b1) begin
                    failCount++;
                    $display("[TB] FAIL clean_pulse_on_rise: got pulse %b any %b want 1 1", pulseA[0], anyA);
                end
            end
            pulses += int'(pulseA[0]);
            anys   += int'(anyA);
        end
        testCount++;
        if (pulses != expHold || anys != expHold) begin
            failCount++;
            $display("[TB] FAIL clean_pulse_count: got %0d/%0d want %0d", pulses, anys, expHold);
        end
        rawA[0] = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge CLK);
            if (k == 3) begin
                testCount++;
                if (levelA[0] !== 1'b1) begin
                    failCount++;
                    $display("[TB] FAIL clean_release_early: got %b want 1", levelA[0]);
                end
            end
            if (k == 6) begin
                testCount++;
                if (levelA[0] !== 1'b0) begin
                    failCount++;
                    $display("[TB] FAIL clean_release_level: got %b want 0", levelA[0]);
                end
            end
            relPulses += int'(pulseA[0]);
        end
        testCount++;
        if (relPulses != expRel || busyA !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL clean_release_pulse: got %0d busy %b want %0d busy 0", relPulses, busyA, expRel);
        end
    endtask

    task automatic test_bounce();
        bit [11:0] pattern;
        bit        busySeen, levelSeen, pulseSeen;
        pattern = 12'b000001110111;
        busySeen = 0; levelSeen = 0; pulseSeen = 0;
        for (int k = 0; k < 12; k++) begin
            rawA[2] = pattern[k];
            @(negedge CLK);
            busySeen  |= (busyA === 1'b1);
            levelSeen |= (levelA[2] !== 1'b0);
            pulseSeen |= (pulseA !== '0);
        end
        repeat (4) @(negedge CLK);
        testCount++;
        if (levelSeen || pulseSeen) begin
            failCount++;
            $display("[TB] FAIL bounce_filtered: got level %b pulse %b want 0 0", levelSeen, pulseSeen);
        end
        testCount++;
        if (!busySeen || busyA !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL bounce_busy: got seen %b final %b want 1 0", busySeen, busyA);
        end
    endtask

    task automatic test_simultaneous_mask();
        logic [N-1:0] pulseOr;
        bit           first;
        pulseOr = '0;
        first   = 1'b1;
        mask    = 6'b000010;
        rawA[1] = 1'b1;
        rawA[3] = 1'b1;
        for (int k = 0; k < 9; k++) begin
            @(negedge CLK);
            if (k == 6) begin
                testCount++;
                if ((levelA & 6'b001010) !== 6'b001010) begin
                    failCount++;
                    $display("[TB] FAIL sim_levels: got %b want 001010", levelA);
                end
            end
            if (first && pulseA !== '0) begin
                first = 1'b0;
                testCount++;
                if (pulseA !== 6'b001000 || anyA !== 1'b1) begin
                    failCount++;
                    $display("[TB] FAIL sim_pulse_vector: got %b any %b want 001000 1", pulseA, anyA);
                end
            end
            pulseOr |= pulseA;
        end
        testCount++;
        if (pulseOr !== 6'b001000) begin
            failCount++;
            $display("[TB] FAIL sim_pulse_union: got %b want 001000", pulseOr);
        end
        rawA[1] = 1'b0;
        rawA[3] = 1'b0;
        repeat (12) @(negedge CLK);
        mask = '0;
    endtask

    task automatic test_reset_mid_count();
        int pulses;
        pulses  = 0;
        rawA[4] = 1'b1;
        repeat (4) @(negedge CLK);
        testCount++;
        if (busyA !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL midrst_busy_before: got %b want 1", busyA);
        end
        RST = 1'b1;
        #1;
        testCount++;
        if ({levelA, pulseA, anyA, busyA} !== '0) begin
            failCount++;
            $display("[TB] FAIL midrst_cleared: got %b want 0", {levelA, pulseA, anyA, busyA});
        end
        @(negedge CLK);
        RST = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge CLK);
            if (k == 3) begin
                testCount++;
                if (levelA[4] !== 1'b0) begin
                    failCount++;
                    $display("[TB] FAIL midrst_level_early: got %b want 0", levelA[4]);
                end
            end
            if (k == 6) begin
                testCount++;
                if (levelA[4] !== 1'b1) begin
                    failCount++;
                    $display("[TB] FAIL midrst_level_high: got %b want 1", levelA[4]);
                end
            end
            pulses += int'(pulseA[4]);
        end
        testCount++;
        if (pulses != 1) begin
            failCount++;
            $display("[TB] FAIL midrst_pulse_count: got %0d want 1", pulses);
        end
        rawA[4] = 1'b0;
        repeat (12) @(negedge CLK);
    endtask

    task automatic test_active_low();
        int pulses, anys;
        pulses  = 0; anys = 0;
        rawB[0] = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge CLK);
            if (k == 3) begin
                testCount++;
                if (levelB[0] !== 1'b0) begin
                    failCount++;
                    $display("[TB] FAIL al_level_early: got %b want 0", levelB[0]);
                end
            end
            if (k == 6) begin
                testCount++;
                if (levelB !== 6'b000001) begin
                    failCount++;
                    $display("[TB] FAIL al_level_high: got %b want 000001", levelB);
                end
            end
            pulses += int'(pulseB[0]);
            anys   += int'(anyB);
        end
        testCount++;
        if (pulses != 1 || anys != 1) begin
            failCount++;
            $display("[TB] FAIL al_pulse_count: got %0d/%0d want 1", pulses, anys);
        end
        rawB[0] = 1'b1;
        repeat (12) @(negedge CLK);
    endtask

`ifdef BTN_AUTO_REPEAT_EN
    task automatic test_auto_repeat();
        int pulses, lateSeen;
        pulses = 0; lateSeen = 0;
        rawA[0] = 1'b1;
        for (int k = 0; k < 30; k++) begin
            @(negedge CLK);
            pulses += int'(pulseA[0]);
        end
        rawA[0] = 1'b0;
        for (int k = 0; k < 16; k++) begin
            @(negedge CLK);
            pulses += int'(pulseA[0]);
            if (k > 1) lateSeen += int'(pulseA[0]);
        end
        testCount++;
        if (pulses != 4 || lateSeen != 0) begin
            failCount++;
            $display("[TB] FAIL repeat_count: got %0d late %0d want 4 late 0", pulses, lateSeen);
        end
    endtask
`endif

    initial begin
        RST   = 1'b1;
        rawA  = '0;
        rawB  = '1;
        mask  = '0;
        maskB = '0;
        @(negedge CLK);
        test_reset();
        test_clean_press();
        test_bounce();
        test_simultaneous_mask();
        test_reset_mid_count();
        test_active_low();
`ifdef BTN_AUTO_REPEAT_EN
        test_auto_repeat();
`endif
        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
